ram_requester: RTL and testbench
================================

Name: ram_requester

Overview:
- Initiator end of the cpu_ram_if RAM protocol.
- Arbitrates instruction-fetch reads and data reads/writes onto the single variable-latency RAM port.
- Holds address, store data and enables stable until the RAM reports ACCESS, then returns the result to the winning requester.
- Sits between the datapath/caches and the RAM responder.

Parameters:
- TIMEOUT, 64: max cycles a granted transaction waits for ACCESS before abort (must be ≥ 2).
- BAD, 32'hBAD1BAD1: load value returned on abort.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction read data.
- iwait  out  1  high while instruction request is pending and not completed.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data.
- dwait  out  1  high while data request is pending and not completed.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid only when ramstate == ACCESS.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- err  out  1  one-cycle pulse on abort or illegal request.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, IREQ, DREQ.
- Reset (RST high at an edge): next state IDLE; ramREN = ramWEN = 0; ramaddr = ramstore = 0; err = 0; timer = 0; last_grant = INSTR. Reset mid-transaction abandons it silently, with no err.
- IDLE:
  - RAM enables are 0.
  - Arbitration picks data if (dREN|dWEN), else instruction if iREN.
  - When both are pending: data wins unless last_grant == DATA, in which case instruction wins (alternating, no starvation).
  - The winner's address, store and direction are latched into regs. The next state is IREQ or DREQ. last_grant is updated.
- IREQ/DREQ:
  - ramaddr and ramstore are driven from the latched regs.
  - IREQ: ramREN = 1.
  - DREQ: ramREN = latched rd, ramWEN = latched wr.
  - Requester inputs are ignored while in these states.
  - The timer increments each cycle in these states.
- Completion: the first cycle in which ramstate == ACCESS.
  - The owning x-wait is driven low that cycle.
  - xload = ramload, combinational passthrough, for reads.
  - Next state is IDLE, so enables drop for at least one cycle between transactions. The responder's counter therefore always restarts.
- Abort:
  - Trigger: ramstate == ERROR, or timer reaches TIMEOUT-1 without ACCESS.
  - Same cycle: owner's x-wait low, xload = BAD, err = 1.
  - Next state: IDLE.
- Wait outputs:
  - iwait = iREN & ~(IREQ & done_or_abort).
  - dwait = (dREN|dWEN) & ~(DREQ & done_or_abort).
  - Both are high in IDLE whenever the corresponding request is asserted.
- Outside its completion cycle, iload/dload = 0.
- Illegal dREN & dWEN together: treated as a write (ramREN = 0, ramWEN = 1), with an err pulse in the IDLE grant cycle.
- Requester deasserts mid-transaction: the transaction still runs to ACCESS and the result is discarded.
- Latency, for a request seen in IDLE at cycle 0 against the LAT=3 responder:
  - grant at cycle 1;
  - ACCESS at cycle 5, so wait is low in cycle 5;
  - IDLE at cycle 6.
  - In general: grant + LAT + 1.

Decomposition:
- cpu_types_pkg already holds ramstate_t and word_t.
- Add to cpu_types_pkg:
  - reqstate_t enum {IDLE, IREQ, DREQ};
  - grant_t enum {INSTR, DATA}.
- One natural sub-module: ram_arbiter, the combinational round-robin/priority pick plus the last_grant register.
- The FSM, latches and timer stay in ram_requester.

Test Plan:
- Single instruction read: iREN=1, iaddr=0x40, responder LAT=3 holding 0x8C010000 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait low only in cycle 5 with iload=0x8C010000; ramREN=0 in cycle 6.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1 and ramstore=0xDEADBEEF held cycles 1-5; dwait low in cycle 5; a later read of 0x100 returns 0xDEADBEEF.
- Contention: iREN and dREN held continuously with last_grant=INSTR -> grants alternate D, I, D, I; neither wait stays high more than 2 transactions.
- Timeout: stub holds ramstate=BUSY, TIMEOUT=8 -> abort in the 8th REQ cycle; dload=0xBAD1BAD1, err pulses once; then IDLE.
- Illegal request plus ERROR: dREN=dWEN=1 -> err pulse at grant, ramWEN=1 and ramREN=0. Separately, stub drives ERROR -> same-cycle abort with err=1.
- Reset mid-transaction: RST=1 at cycle 3 of IREQ -> at the next edge ramREN=0, state IDLE, err=0; a new request afterwards completes normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM handshake types: RAM responder status, requester FSM states
// and the arbitration grant owner.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, IREQ, DREQ} reqstate_t;

    typedef enum logic {INSTR, DATA} grant_t;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin pick between instruction and data requests.
// The last winner loses the next tie, so neither side can starve.
module ram_arbiter
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   en,
    input  logic   irq,
    input  logic   drq,
    output logic   valid,
    output grant_t pick
);

    grant_t last_grant;

    always_comb begin
        valid = en & (irq | drq);
        pick  = (drq && (!irq || last_grant == INSTR)) ? DATA : INSTR;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            last_grant <= INSTR;
        else if (valid)
            last_grant <= pick;
    end

endmodule

// File: rtl/ram_requester.sv
// Initiator side of the cpu_ram_if port: arbitrates fetch and data accesses,
// holds the RAM request stable until ACCESS/ERROR/timeout, returns the result.
//
// state | meaning
// IDLE  | enables low, arbitrate and latch the winning request
// IREQ  | instruction read outstanding on the RAM port
// DREQ  | data read or write outstanding on the RAM port
module ram_requester
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT = 64,
    parameter word_t BAD     = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    reqstate_t     state;
    logic [TW-1:0] timer;
    logic          gvalid;
    grant_t        gpick;
    logic          busy, done, abort, fin;

    ram_arbiter u_arb (
        .CLK   (CLK),
        .RST   (RST),
        .en    (state == IDLE),
        .irq   (iREN),
        .drq   (dREN | dWEN),
        .valid (gvalid),
        .pick  (gpick)
    );

    always_comb begin
        busy  = (state != IDLE);
        done  = busy && (ramstate == ACCESS);
        abort = busy && (ramstate != ACCESS)
                && ((ramstate == ERROR) || (timer == TW'(TIMEOUT - 1)));
        fin   = done | abort;

        iwait = iREN & ~((state == IREQ) & fin);
        dwait = (dREN | dWEN) & ~((state == DREQ) & fin);

        iload = '0;
        if (state == IREQ && done)
            iload = ramload;
        else if (state == IREQ && abort)
            iload = BAD;

        // ramREN holds the latched read direction while in DREQ
        dload = '0;
        if (state == DREQ && done && ramREN)
            dload = ramload;
        else if (state == DREQ && abort)
            dload = BAD;

        err = abort | (gvalid && gpick == DATA && dREN && dWEN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gvalid) begin
                        timer <= '0;
                        if (gpick == DATA) begin
                            state    <= DREQ;
                            ramaddr  <= daddr;
                            ramstore <= dstore;
                            ramREN   <= dREN & ~dWEN;
                            ramWEN   <= dWEN;
                        end else begin
                            state    <= IREQ;
                            ramaddr  <= iaddr;
                            ramstore <= '0;
                            ramREN   <= 1'b1;
                            ramWEN   <= 1'b0;
                        end
                    end
                end
                default: begin
                    timer <= timer + TW'(1);
                    if (fin) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_requester.sv
// Directed bench for ram_requester against a LAT=3 responder model that can
// also be forced to stall (BUSY) or fail (ERROR).
module tb_ram_requester;
    import cpu_types_pkg::*;

    localparam int    LAT = 3;
    localparam word_t BADV = 32'hBAD1BAD1;
    localparam word_t IWORD = 32'h8C010000;
    localparam word_t DWORD = 32'hDEADBEEF;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, err;
    ramstate_t ramstate;

    int    checks = 0;
    int    errors = 0;
    int    mode;
    int    cnt;
    word_t mem [0:255];
    logic  en;

    ram_requester #(.TIMEOUT(8), .BAD(BADV)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    // responder: ACCESS in the (LAT+2)th cycle the enable has been held
    assign en      = ramREN | ramWEN;
    assign ramload = mem[ramaddr[9:2]];

    always_comb begin
        ramstate = FREE;
        if (en) begin
            if (mode == 1)
                ramstate = BUSY;
            else if (mode == 2)
                ramstate = ERROR;
            else
                ramstate = (cnt == LAT + 1) ? ACCESS : BUSY;
        end
    end

    always @(posedge CLK) begin
        cnt <= en ? cnt + 1 : 0;
        if (en && ramWEN && ramstate == ACCESS)
            mem[ramaddr[9:2]] <= ramstore;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        mem[16] = IWORD;
        mode = 0;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        next(); next();
        chk1("rst_ren", ramREN, 1'b0);
        chk1("rst_wen", ramWEN, 1'b0);
        chk32("rst_addr", ramaddr, 32'h0);
        chk32("rst_store", ramstore, 32'h0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_iwait", iwait, 1'b0);
        RST = 1'b0;

        // single instruction read
        next(); iREN = 1'b1; iaddr = 32'h40; #1;
        chk1("ird_c0_wait", iwait, 1'b1);
        chk1("ird_c0_ren", ramREN, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next();
            chk1("ird_ren", ramREN, 1'b1);
            chk32("ird_addr", ramaddr, 32'h40);
            chk1("ird_wait", iwait, 1'b1);
        end
        next();
        chk1("ird_c5_wait", iwait, 1'b0);
        chk32("ird_c5_load", iload, IWORD);
        chk1("ird_c5_err", err, 1'b0);
        iREN = 1'b0;
        next();
        chk1("ird_c6_ren", ramREN, 1'b0);
        chk32("ird_c6_load", iload, 32'h0);

        // data write then read-back
        next(); dWEN = 1'b1; daddr = 32'h100; dstore = DWORD; #1;
        chk1("dwr_c0_wait", dwait, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            next();
            chk1("dwr_wen", ramWEN, 1'b1);
            chk1("dwr_ren", ramREN, 1'b0);
            chk32("dwr_store", ramstore, DWORD);
            chk1("dwr_wait", dwait, k != 5);
        end
        dWEN = 1'b0;
        next();
        chk1("dwr_c6_wen", ramWEN, 1'b0);
        next(); dREN = 1'b1; daddr = 32'h100;
        for (int k = 1; k <= 5; k++) begin
            next();
            chk1("drd_wait", dwait, k != 5);
            chk32("drd_load", dload, (k == 5) ? DWORD : 32'h0);
        end
        dREN = 1'b0;
        next();

        // contention from a fresh last_grant=INSTR: D, I, D, I
        RST = 1'b1; next(); RST = 1'b0;
        next(); iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h100;
        for (int t = 0; t < 4; t++) begin
            for (int k = 1; k <= 6; k++) begin
                next();
                if (k == 1) begin
                    chk32("arb_addr", ramaddr, (t % 2 == 0) ? 32'h100 : 32'h40);
                    chk1("arb_ren", ramREN, 1'b1);
                end else if (k == 5) begin
                    chk1("arb_dwait", dwait, t % 2 != 0);
                    chk1("arb_iwait", iwait, t % 2 == 0);
                    if (t % 2 == 0) chk32("arb_dload", dload, DWORD);
                    else            chk32("arb_iload", iload, IWORD);
                    if (t == 3) begin iREN = 1'b0; dREN = 1'b0; end
                end else if (k == 6) begin
                    chk1("arb_gap", ramREN, 1'b0);
                end
            end
        end

        // timeout with a stalled responder
        mode = 1;
        next(); dREN = 1'b1; daddr = 32'h200; #1;
        chk1("to_c0_err", err, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            next();
            chk1("to_wait", dwait, k != 8);
            chk1("to_err", err, k == 8);
            chk32("to_load", dload, (k == 8) ? BADV : 32'h0);
        end
        dREN = 1'b0;
        next();
        chk1("to_after_err", err, 1'b0);
        chk1("to_after_ren", ramREN, 1'b0);
        mode = 0;

        // illegal read+write request
        next(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h104; dstore = 32'h12345678; #1;
        chk1("ill_c0_err", err, 1'b1);
        chk1("ill_c0_wait", dwait, 1'b1);
        next();
        chk1("ill_c1_err", err, 1'b0);
        chk1("ill_c1_wen", ramWEN, 1'b1);
        chk1("ill_c1_ren", ramREN, 1'b0);
        next(); next(); next(); next();
        chk1("ill_c5_wait", dwait, 1'b0);
        chk32("ill_c5_load", dload, 32'h0);
        dREN = 1'b0; dWEN = 1'b0;
        next();
        chk1("ill_c6_wen", ramWEN, 1'b0);

        // responder ERROR aborts in the same cycle
        mode = 2;
        next(); iREN = 1'b1; iaddr = 32'h40; #1;
        next();
        chk1("er_wait", iwait, 1'b0);
        chk32("er_load", iload, BADV);
        chk1("er_err", err, 1'b1);
        iREN = 1'b0;
        next();
        chk1("er_after_ren", ramREN, 1'b0);
        chk1("er_after_err", err, 1'b0);
        mode = 0;

        // reset in the middle of an instruction read
        next(); iREN = 1'b1; iaddr = 32'h40;
        next(); next(); next();
        chk1("mr_c3_ren", ramREN, 1'b1);
        RST = 1'b1; iREN = 1'b0;
        next();
        chk1("mr_ren", ramREN, 1'b0);
        chk1("mr_err", err, 1'b0);
        chk1("mr_iwait", iwait, 1'b0);
        RST = 1'b0;
        next(); iREN = 1'b1; iaddr = 32'h40; #1;
        chk1("mr2_c0_ren", ramREN, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            next();
            chk1("mr2_wait", iwait, k != 5);
        end
        chk32("mr2_load", iload, IWORD);
        iREN = 1'b0;
        next();
        chk1("mr2_c6_ren", ramREN, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
